// File: rtl/led_shift_ctrl.sv
// LED pattern stepper: advances a W-bit pattern once per rising edge of the slow tick.
// Optional per-step counter output `step_cnt` is enabled by defining LED_STEP_COUNT_EN.
//
// mode    | meaning
// M_ROT_L | rotate left, MSB wraps to bit0
// M_ROT_R | rotate right, bit0 wraps to MSB
// M_PING  | single lit LED bounces between ends, dir tracks travel
// M_BAR   | bar graph fills from bit0, then clears
module led_shift_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         en,
  input  logic [1:0]   sw,
`ifdef LED_STEP_COUNT_EN
  output logic [7:0]   step_cnt,
`endif
  output logic [W-1:0] led
);

  typedef enum logic [1:0] {
    M_ROT_L = 2'b00,
    M_ROT_R = 2'b01,
    M_PING  = 2'b10,
    M_BAR   = 2'b11
  } mode_t;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MSB = {1'b1, {(W-1){1'b0}}};

  mode_t        mode;
  mode_t        sw_mode;
  mode_t        nxt_mode;
  logic [1:0]   sw_q;
  logic         tick_d;
  logic         dir_right;
  logic         nxt_dir;
  logic         step;
  logic         onehot;
  logic [W-1:0] nxt_led;
  logic [W-1:0] shl;
  logic [W-1:0] shr;

  function automatic logic [W-1:0] seed(input mode_t m);
    case (m)
      M_ROT_R: seed = MSB;
      M_BAR:   seed = '0;
      default: seed = ONE;
    endcase
  endfunction

  assign sw_mode = mode_t'(sw_q);
  assign step    = tick & ~tick_d & en;
  assign onehot  = (led != '0) && ((led & (led - ONE)) == '0);
  assign shl     = {led[W-2:0], 1'b0};
  assign shr     = {1'b0, led[W-1:1]};

  always_comb begin
    nxt_mode = mode;
    nxt_led  = led;
    nxt_dir  = dir_right;
    if (sw_mode != mode) begin
      nxt_mode = sw_mode;
      nxt_led  = seed(sw_mode);
      nxt_dir  = 1'b0;
    end else if (mode == M_BAR) begin
      nxt_led = (led == '1) ? '0 : {led[W-2:0], 1'b1};
    end else if (!onehot) begin
      // a corrupted single-LED pattern is reseeded rather than propagated
      nxt_led = seed(mode);
      nxt_dir = 1'b0;
    end else begin
      case (mode)
        M_ROT_L: nxt_led = {led[W-2:0], led[W-1]};
        M_ROT_R: nxt_led = {led[0], led[W-1:1]};
        default: begin
          if (!dir_right) begin
            nxt_led = shl;
            if (shl[W-1]) nxt_dir = 1'b1;
          end else begin
            nxt_led = shr;
            if (shr[0]) nxt_dir = 1'b0;
          end
        end
      endcase
    end
  end

  // tick_d resets high so a tick already high at release is not an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_d    <= 1'b1;
      sw_q      <= 2'b00;
      mode      <= M_ROT_L;
      dir_right <= 1'b0;
      led       <= ONE;
    end else begin
      tick_d <= tick;
      sw_q   <= sw;
      if (step) begin
        mode      <= nxt_mode;
        led       <= nxt_led;
        dir_right <= nxt_dir;
      end
    end
  end

`ifdef LED_STEP_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_cnt <= 8'h00;
    end else if (step) begin
      step_cnt <= step_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_led_shift_ctrl.sv
// Directed self-checking bench for led_shift_ctrl (W=8).
// Counter checks are compiled in when LED_STEP_COUNT_EN is defined.
module tb_led_shift_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         tick;
  logic         en;
  logic [1:0]   sw;
  logic [W-1:0] led;
`ifdef LED_STEP_COUNT_EN
  logic [7:0]   step_cnt;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]   sw;
    logic         en;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  led_shift_ctrl #(.W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .en       (en),
    .sw       (sw),
`ifdef LED_STEP_COUNT_EN
    .step_cnt (step_cnt),
`endif
    .led      (led)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // tick low for 3 clocks then high for 3: exactly one rising edge
  task automatic tick_edge(input logic [1:0] s, input logic e);
    @(negedge clk);
    sw   = s;
    en   = e;
    tick = 1'b0;
    repeat (3) @(negedge clk);
    tick = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  function automatic void add(input logic [1:0] s, input logic e, input logic [W-1:0] x);
    vec_t v;
    v.sw  = s;
    v.en  = e;
    v.exp = x;
    vecs.push_back(v);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // rotate-left continuation after the first hand-checked step
    add(2'b00, 1'b1, 8'h04); add(2'b00, 1'b1, 8'h08); add(2'b00, 1'b1, 8'h10);
    add(2'b00, 1'b1, 8'h20); add(2'b00, 1'b1, 8'h40); add(2'b00, 1'b1, 8'h80);
    add(2'b00, 1'b1, 8'h01); add(2'b00, 1'b1, 8'h02);
    // ping-pong: reload then bounce
    add(2'b10, 1'b1, 8'h01);
    add(2'b10, 1'b1, 8'h02); add(2'b10, 1'b1, 8'h04); add(2'b10, 1'b1, 8'h08);
    add(2'b10, 1'b1, 8'h10); add(2'b10, 1'b1, 8'h20); add(2'b10, 1'b1, 8'h40);
    add(2'b10, 1'b1, 8'h80); add(2'b10, 1'b1, 8'h40); add(2'b10, 1'b1, 8'h20);
    add(2'b10, 1'b1, 8'h10); add(2'b10, 1'b1, 8'h08); add(2'b10, 1'b1, 8'h04);
    add(2'b10, 1'b1, 8'h02); add(2'b10, 1'b1, 8'h01); add(2'b10, 1'b1, 8'h02);
    add(2'b10, 1'b1, 8'h04);
    // bar fill: reload then fill and clear
    add(2'b11, 1'b1, 8'h00);
    add(2'b11, 1'b1, 8'h01); add(2'b11, 1'b1, 8'h03); add(2'b11, 1'b1, 8'h07);
    add(2'b11, 1'b1, 8'h0F); add(2'b11, 1'b1, 8'h1F); add(2'b11, 1'b1, 8'h3F);
    add(2'b11, 1'b1, 8'h7F); add(2'b11, 1'b1, 8'hFF); add(2'b11, 1'b1, 8'h00);
    // back to rotate-left, then freeze while switching to rotate-right
    add(2'b00, 1'b1, 8'h01);
    add(2'b01, 1'b0, 8'h01); add(2'b01, 1'b0, 8'h01); add(2'b01, 1'b0, 8'h01);
    add(2'b01, 1'b1, 8'h80); add(2'b01, 1'b1, 8'h40); add(2'b01, 1'b1, 8'h20);

    reset = 1'b1;
    tick  = 1'b1;
    en    = 1'b1;
    sw    = 2'b00;
    #35;
    check("reset_led", led, 8'h01);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("tick_high_at_release", led, 8'h01);
    tick = 1'b0;
    repeat (2) @(negedge clk);
    check("tick_fall_no_step", led, 8'h01);
    tick = 1'b1;
    @(negedge clk);
    check("first_step_latency", led, 8'h02);
    repeat (3) @(negedge clk);
    check("one_step_per_edge", led, 8'h02);

    for (int i = 0; i < vecs.size(); i++) begin
      tick_edge(vecs[i].sw, vecs[i].en);
      check($sformatf("vec%0d_sw%b_en%b", i, vecs[i].sw, vecs[i].en), led, vecs[i].exp);
    end

    // asynchronous reset mid-sequence, between clock edges
    @(posedge clk);
    #5 reset = 1'b1;
    #1;
    check("async_reset_led", led, 8'h01);
`ifdef LED_STEP_COUNT_EN
    check("async_reset_cnt", step_cnt, 8'h00);
`endif
    tick = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_no_edge", led, 8'h01);
    tick_edge(2'b00, 1'b1);
    check("post_reset_fresh_edge", led, 8'h02);

`ifdef LED_STEP_COUNT_EN
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("cnt_after_reset", step_cnt, 8'h00);
    for (int i = 0; i < 257; i++) tick_edge(2'b00, 1'b1);
    check("cnt_wrap_257", step_cnt, 8'h01);
    check("led_after_257", led, 8'h02);
    tick_edge(2'b00, 1'b0);
    check("cnt_hold_en0", step_cnt, 8'h01);
    tick_edge(2'b00, 1'b1);
    check("cnt_step_258", step_cnt, 8'h02);
    @(posedge clk);
    #5 reset = 1'b1;
    #1;
    check("cnt_async_reset", step_cnt, 8'h00);
    check("cnt_async_reset_led", led, 8'h01);
    @(negedge clk);
    reset = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
